div32: RTL and testbench

Sequential 32-bit unsigned restoring divider. It is the inverse-operation counterpart to the shift-add multiplier in the ALU datapath.
It accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, and presents quotient and remainder with a done flag.
It is intended to sit beside the ALU as a multi-cycle execution unit feeding the result mux.

---
 rtl/div32_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/div32.sv | 109 ++++++++++
 tb/tb_div32.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div32_pkg.sv
// Shared definitions for the div32 sequential restoring divider:
// state encoding, default operand width and iteration-counter width.
package div32_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = $clog2(DIV_WIDTH);

   // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor at WIDTH+1 bits, and keep the difference only when it did not borrow.
module div_step
   import div32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] dvs_inv;
   logic [WIDTH:0] trial;

   assign shifted = {rem, q_msb};

   // Subtract as an add of the inverted divisor with carry-in 1; the extra top bit is the borrow.
   assign dvs_inv = ~{1'b0, dvs};
   assign trial   = shifted + dvs_inv + {{WIDTH{1'b0}}, 1'b1};

   assign q_bit = ~trial[WIDTH];

   // Either result is below the divisor, so it always fits in WIDTH bits.
   assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations,
// result held with done until the next accepted start. Divide-by-zero finishes in one cycle.
module div32
   import div32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   // The partial remainder's 33rd bit is provably always zero between iterations,
   // so only WIDTH bits are stored; the wide trial lives inside div_step.
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] dvs, dvs_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dbz, dbz_nxt;

   logic [WIDTH-1:0] step_rem;
   logic             step_bit;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem),
      .q_msb    (quo[WIDTH-1]),
      .dvs      (dvs),
      .rem_next (step_rem),
      .q_bit    (step_bit)
   );

   always_comb begin
      state_nxt = state;
      quo_nxt   = quo;
      rem_nxt   = rem;
      dvs_nxt   = dvs;
      cnt_nxt   = cnt;
      dbz_nxt   = dbz;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               if (b == '0) begin
                  state_nxt = DONE;
                  quo_nxt   = '1;
                  rem_nxt   = a;
                  dbz_nxt   = 1'b1;
               end else begin
                  state_nxt = RUN;
                  dvs_nxt   = b;
                  quo_nxt   = a;
                  rem_nxt   = '0;
                  cnt_nxt   = '0;
                  dbz_nxt   = 1'b0;
               end
            end
         end
         RUN: begin
            quo_nxt = {quo[WIDTH-2:0], step_bit};
            rem_nxt = step_rem;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_CNT) begin
               state_nxt = DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         dbz   <= 1'b0;
      end else begin
         state <= state_nxt;
         quo   <= quo_nxt;
         rem   <= rem_nxt;
         dvs   <= dvs_nxt;
         cnt   <= cnt_nxt;
         dbz   <= dbz_nxt;
      end
   end

   assign quotient    = quo;
   assign remainder   = rem;
   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign div_by_zero = dbz;

   busy_done_exclusive : assert property (@(posedge CLK) disable iff (!RST_N) !(busy && done));

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed corner cases plus randomized operands,
// checked against a plain-arithmetic reference model.
module tb_div32;

   logic        CLK   = 1'b0;
   logic        RST_N = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int n_cmp   = 0;
   int n_bad   = 0;
   int bd_viol = 0;

   div32 dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .start       (start),
      .a           (a),
      .b           (b),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (busy && done) bd_viol++;
   end

   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output int lat);
      if (y == 0) begin
         q = 32'hFFFF_FFFF; r = x; dz = 1'b1; lat = 0;
      end else begin
         q = x / y; r = x % y; dz = 1'b0; lat = 32;
      end
   endfunction

   // Present operands for one edge, then scramble them so later changes are shown harmless.
   task automatic issue(input logic [31:0] av, input logic [31:0] bv);
      @(negedge CLK);
      start = 1'b1; a = av; b = bv;
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge CLK);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset;
      #2 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
      n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL reset_quot: got %h want 0", quotient); end
      n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL reset_rem: got %h want 0", remainder); end
      RST_N = 1'b1;
      @(negedge CLK);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", busy, done); end
   endtask

   task automatic test_directed;
      logic [31:0] av [6] = '{32'd100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hDEAD_BEEF};
      logic [31:0] bv [6] = '{32'd7, 32'd3, 32'd1, 32'd100, 32'd5, 32'hFFFF_FFFF};
      logic [31:0] eq, er;
      logic        edz;
      int          elat, lat;
      for (int i = 0; i < 6; i++) begin
         model(av[i], bv[i], eq, er, edz, elat);
         issue(av[i], bv[i]);
         n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy: got %b want 1", i, busy); end
         wait_done(lat);
         n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat); end
         n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL dir%0d_quot: got %h want %h", i, quotient, eq); end
         n_cmp++; if (remainder !== er) begin n_bad++; $display("FAIL dir%0d_rem: got %h want %h", i, remainder, er); end
         n_cmp++; if (div_by_zero !== edz) begin n_bad++; $display("FAIL dir%0d_dbz: got %b want %b", i, div_by_zero, edz); end
      end
   endtask

   task automatic test_div_by_zero;
      int lat;
      issue(32'd5, 32'd0);
      wait_done(lat);
      n_cmp++; if (lat != 0) begin n_bad++; $display("FAIL dbz_latency: got %0d want 0", lat); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
      n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_quot: got %h want ffffffff", quotient); end
      n_cmp++; if (remainder !== 32'd5) begin n_bad++; $display("FAIL dbz_rem: got %h want 5", remainder); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dbz_busy: got %b want 0", busy); end
      issue(32'd9, 32'd2);
      n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
      wait_done(lat);
      n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL after_dbz_latency: got %0d want 32", lat); end
      n_cmp++; if (quotient !== 32'd4 || remainder !== 32'd1) begin
         n_bad++; $display("FAIL after_dbz_result: got q=%0d r=%0d want q=4 r=1", quotient, remainder);
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      issue(32'd100, 32'd7);
      repeat (9) @(negedge CLK);
      start = 1'b1; a = 32'd1; b = 32'd1;
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy: got %b want 1", busy); end
      wait_done(lat);
      n_cmp++; if (lat != 22) begin n_bad++; $display("FAIL ignore_latency: got %0d want 22", lat); end
      n_cmp++; if (quotient !== 32'd14 || remainder !== 32'd2) begin
         n_bad++; $display("FAIL ignore_result: got q=%0d r=%0d want q=14 r=2", quotient, remainder);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] av, bv, eq, er;
      logic        edz;
      int          elat, lat;
      repeat (5) @(negedge CLK);
      n_cmp++; if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
         n_bad++; $display("FAIL hold_done: got done=%b q=%0d r=%0d want 1/14/2", done, quotient, remainder);
      end
      av = $urandom; bv = $urandom_range(1, 1000);
      model(av, bv, eq, er, edz, elat);
      issue(av, bv);
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
         n_bad++; $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done);
      end
      wait_done(lat);
      n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, elat); end
      n_cmp++; if (quotient !== eq || remainder !== er) begin
         n_bad++; $display("FAIL b2b_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, eq, er);
      end
   endtask

   task automatic test_async_reset;
      int lat;
      issue(32'd1000, 32'd3);
      repeat (14) @(negedge CLK);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL areset_ctrl: got busy=%b done=%b want 0/0", busy, done);
      end
      n_cmp++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
         n_bad++; $display("FAIL areset_data: got q=%h r=%h dz=%b want 0/0/0", quotient, remainder, div_by_zero);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      issue(32'd1000, 32'd3);
      wait_done(lat);
      n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL areset_relatency: got %0d want 32", lat); end
      n_cmp++; if (quotient !== 32'd333 || remainder !== 32'd1) begin
         n_bad++; $display("FAIL areset_result: got q=%0d r=%0d want q=333 r=1", quotient, remainder);
      end
   endtask

   task automatic test_random;
      logic [31:0] av, bv, eq, er;
      logic        edz;
      int          elat, lat;
      for (int i = 0; i < 24; i++) begin
         av = $urandom;
         case ($urandom_range(0, 3))
            0:       bv = 32'd0;
            1:       bv = $urandom_range(1, 16);
            2:       bv = $urandom;
            default: bv = $urandom | 32'h8000_0000;
         endcase
         model(av, bv, eq, er, edz, elat);
         issue(av, bv);
         wait_done(lat);
         n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
         n_cmp++; if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
            n_bad++;
            $display("FAIL rnd%0d_result a=%h b=%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     i, av, bv, quotient, remainder, div_by_zero, eq, er, edz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_by_zero();
      test_ignore_start();
      test_back_to_back();
      test_async_reset();
      test_random();
      n_cmp++; if (bd_viol != 0) begin n_bad++; $display("FAIL busy_done_overlap: got %0d cycles want 0", bd_viol); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
